// File: rtl/fft_out_serializer.sv
// Captures a full 32-bin FFT result on the out_en rising edge and streams it one bin per beat.
// Build option: define FFT_SER_BITREV_EN to emit bins in 5-bit bit-reversed order.
module fft_out_serializer #(
  parameter int N = 16,
  parameter int Q = 8,
  localparam int IDXW = 5
) (
  input  logic              clk2,
  input  logic              rst,
  input  logic              out_en,
  input  logic [32*N-1:0]   bins_r,
  input  logic [32*N-1:0]   bins_i,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [N-1:0]      s_data_r,
  output logic [N-1:0]      s_data_i,
  output logic [IDXW-1:0]   s_idx,
  output logic              s_sof,
  output logic              s_last,
  output logic              busy,
  output logic              ovf
);

  localparam int BINS = 32;
  localparam logic [IDXW-1:0] LAST_BEAT = 5'd31;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // Q only describes the number format of the bins; reject nonsensical values at elaboration.
  if (Q < 0 || Q >= N) begin : g_q_range
    $error("fft_out_serializer: Q must lie in [0, N)");
  end

  // Maps a beat number onto the buffer bin it emits.
  function automatic logic [IDXW-1:0] beat_to_bin(input logic [IDXW-1:0] b);
`ifdef FFT_SER_BITREV_EN
    return {b[0], b[1], b[2], b[3], b[4]};
`else
    return b;
`endif
  endfunction

  state_t                state;
  logic [IDXW-1:0]       beat;
  logic                  en_q;
  logic signed [N-1:0]   buf_r_p0 [BINS];
  logic signed [N-1:0]   buf_i_p0 [BINS];

  logic                  cap;
  logic                  accept;
  logic                  frame_end;
  logic                  take;
  logic                  drop;
  logic [IDXW-1:0]       beat_nxt;
  logic [IDXW-1:0]       rd_bin;
  logic [IDXW-1:0]       first_bin;

  always_comb begin
    cap       = out_en & ~en_q;
    accept    = s_valid & s_ready;
    frame_end = (state == STREAM) & accept & (beat == LAST_BEAT);
    // A capture landing on the final accept chains straight into the next frame.
    take      = cap & ((state == IDLE) | frame_end);
    drop      = cap & (state == STREAM) & ~frame_end;
    beat_nxt  = beat + 5'd1;
    rd_bin    = beat_to_bin(beat_nxt);
    first_bin = beat_to_bin('0);
  end

  // Stage 0: frame buffer, written only in the capture cycle
  always_ff @(posedge clk2) begin
    if (take) begin
      for (int k = 0; k < BINS; k++) begin
        buf_r_p0[k] <= bins_r[k*N +: N];
        buf_i_p0[k] <= bins_i[k*N +: N];
      end
    end
  end

  // Stage 1: control state and registered stream outputs
  always_ff @(posedge clk2) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= '0;
      en_q     <= 1'b0;
      ovf      <= 1'b0;
      s_valid  <= 1'b0;
      busy     <= 1'b0;
      s_sof    <= 1'b0;
      s_last   <= 1'b0;
      s_idx    <= '0;
      s_data_r <= '0;
      s_data_i <= '0;
    end else begin
      en_q <= out_en;
      if (drop) begin
        ovf <= 1'b1;
      end
      if (take) begin
        // The buffer is being written this cycle, so beat 0 comes straight from the inputs.
        state    <= STREAM;
        beat     <= '0;
        s_valid  <= 1'b1;
        busy     <= 1'b1;
        s_sof    <= 1'b1;
        s_last   <= 1'b0;
        s_idx    <= first_bin;
        s_data_r <= bins_r[int'(first_bin)*N +: N];
        s_data_i <= bins_i[int'(first_bin)*N +: N];
      end else if (frame_end) begin
        state    <= IDLE;
        beat     <= '0;
        s_valid  <= 1'b0;
        busy     <= 1'b0;
        s_sof    <= 1'b0;
        s_last   <= 1'b0;
        s_idx    <= '0;
        s_data_r <= '0;
        s_data_i <= '0;
      end else if ((state == STREAM) && accept) begin
        beat     <= beat_nxt;
        s_sof    <= 1'b0;
        s_last   <= (beat_nxt == LAST_BEAT);
        s_idx    <= rd_bin;
        s_data_r <= buf_r_p0[rd_bin];
        s_data_i <= buf_i_p0[rd_bin];
      end
    end
  end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer: streaming, back-pressure, held enable,
// overrun, back-to-back frames, mid-frame reset and (when built with FFT_SER_BITREV_EN) bin order.
module tb_fft_out_serializer;

  localparam int N = 16;

  logic            clk2 = 1'b0;
  logic            rst;
  logic            out_en;
  logic [32*N-1:0] bins_r;
  logic [32*N-1:0] bins_i;
  logic            s_valid;
  logic            s_ready;
  logic [N-1:0]    s_data_r;
  logic [N-1:0]    s_data_i;
  logic [4:0]      s_idx;
  logic            s_sof;
  logic            s_last;
  logic            busy;
  logic            ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int order [32];

  fft_out_serializer #(.N(N), .Q(8)) dut (
    .clk2     (clk2),
    .rst      (rst),
    .out_en   (out_en),
    .bins_r   (bins_r),
    .bins_i   (bins_i),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data_r (s_data_r),
    .s_data_i (s_data_i),
    .s_idx    (s_idx),
    .s_sof    (s_sof),
    .s_last   (s_last),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #20 clk2 = ~clk2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame patterns: 0 = (k*256, -k), 1 = (0x7000+3k, 0x8000+k), 2 = (k, 0).
  function automatic logic [15:0] exp_r(input int kind, input int bin);
    case (kind)
      0:       return 16'(bin * 256);
      1:       return 16'(16'h7000 + bin * 3);
      default: return 16'(bin);
    endcase
  endfunction

  function automatic logic [15:0] exp_i(input int kind, input int bin);
    case (kind)
      0:       return 16'(-bin);
      1:       return 16'(16'h8000 + bin);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic load_bins(input int kind);
    for (int k = 0; k < 32; k++) begin
      bins_r[k*N +: N] = exp_r(kind, k);
      bins_i[k*N +: N] = exp_i(kind, k);
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_ovf);
    chk({tag, "_valid"}, 32'(s_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),    32'd0);
    chk({tag, "_sof"},   32'(s_sof),   32'd0);
    chk({tag, "_last"},  32'(s_last),  32'd0);
    chk({tag, "_idx"},   32'(s_idx),   32'd0);
    chk({tag, "_dr"},    32'(s_data_r), 32'd0);
    chk({tag, "_di"},    32'(s_data_i), 32'd0);
    chk({tag, "_ovf"},   32'(ovf),     32'(exp_ovf));
  endtask

  // Drive the capturing edge; returns on the negedge after the capture.
  task automatic start_frame(input int kind);
    load_bins(kind);
    out_en  = 1'b1;
    s_ready = 1'b1;
    @(negedge clk2);
  endtask

  // Consume one frame starting on the negedge after capture; optionally raise out_en again at beat rise_beat.
  task automatic run_frame(input string tag, input int kind, input bit toggle, input int en_hold,
                           input int rise_beat, input int rise_kind, output int cycles);
    int k = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    bit risen = 1'b0;
    logic [15:0] sv_r, sv_i;
    logic [4:0]  sv_idx;
    logic        sv_sof, sv_last;
    while (k < 32 && cyc < 200) begin
      out_en = (cyc < en_hold);
      if (k == rise_beat && !risen) begin
        load_bins(rise_kind);
        out_en = 1'b1;
        risen  = 1'b1;
      end
      s_ready = toggle ? ~cyc[0] : 1'b1;
      chk($sformatf("%s_c%0d_valid", tag, cyc), 32'(s_valid), 32'd1);
      chk($sformatf("%s_c%0d_busy", tag, cyc), 32'(busy), 32'd1);
      if (stalled) begin
        chk($sformatf("%s_c%0d_hold", tag, cyc), {s_data_r, s_data_i},
            {sv_r, sv_i});
        chk($sformatf("%s_c%0d_holdctl", tag, cyc), {25'd0, s_idx, s_sof, s_last},
            {25'd0, sv_idx, sv_sof, sv_last});
      end
      if (s_ready) begin
        chk($sformatf("%s_b%0d_idx", tag, k), 32'(s_idx), 32'(order[k]));
        chk($sformatf("%s_b%0d_dr", tag, k), 32'(s_data_r), 32'(exp_r(kind, order[k])));
        chk($sformatf("%s_b%0d_di", tag, k), 32'(s_data_i), 32'(exp_i(kind, order[k])));
        chk($sformatf("%s_b%0d_sof", tag, k), 32'(s_sof), 32'(k == 0));
        chk($sformatf("%s_b%0d_last", tag, k), 32'(s_last), 32'(k == 31));
        k++;
        stalled = 1'b0;
      end else begin
        sv_r = s_data_r; sv_i = s_data_i; sv_idx = s_idx; sv_sof = s_sof; sv_last = s_last;
        stalled = 1'b1;
      end
      cyc++;
      @(negedge clk2);
    end
    if (k < 32) chk({tag, "_timeout_beats"}, 32'(k), 32'd32);
    cycles = cyc;
  endtask

  initial begin
    int cycles;
`ifdef FFT_SER_BITREV_EN
    order = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
              1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};
`else
    for (int k = 0; k < 32; k++) order[k] = k;
`endif
    rst = 1'b1; out_en = 1'b0; s_ready = 1'b0; bins_r = '0; bins_i = '0;
    repeat (2) @(negedge clk2);
    check_idle("rst", 1'b0);
    rst = 1'b0;
    @(negedge clk2);

    // Natural stream with sink always ready
    start_frame(0);
    run_frame("t1", 0, 1'b0, 0, -1, 0, cycles);
    chk("t1_cycles", 32'(cycles), 32'd32);
    check_idle("t1_end", 1'b0);
    repeat (2) @(negedge clk2);

    // Alternating back-pressure
    start_frame(0);
    run_frame("t2", 0, 1'b1, 0, -1, 0, cycles);
    chk("t2_cycles", 32'(cycles), 32'd63);
    check_idle("t2_end", 1'b0);
    repeat (2) @(negedge clk2);

    // out_en held high for 10 cycles
    start_frame(1);
    run_frame("t3", 1, 1'b0, 9, -1, 0, cycles);
    repeat (3) @(negedge clk2);
    check_idle("t3_end", 1'b0);

    // Overrun at beat 10: old frame intact, new one dropped
    start_frame(0);
    run_frame("t4a", 0, 1'b0, 0, 10, 1, cycles);
    out_en = 1'b0;
    repeat (3) @(negedge clk2);
    check_idle("t4a_end", 1'b1);

    rst = 1'b1;
    @(negedge clk2);
    rst = 1'b0;
    check_idle("t4_rst", 1'b0);

    // Rise on the final accept: back-to-back frames
    start_frame(0);
    run_frame("t4b_f0", 0, 1'b0, 0, 31, 1, cycles);
    run_frame("t4b_f1", 1, 1'b0, 0, -1, 0, cycles);
    check_idle("t4b_end", 1'b0);
    repeat (2) @(negedge clk2);

    // Reset while beat 15 is presented
    start_frame(0);
    out_en = 1'b0;
    repeat (15) @(negedge clk2);
    chk("t5_pre_idx", 32'(s_idx), 32'(order[15]));
    rst = 1'b1;
    @(negedge clk2);
    rst = 1'b0;
    check_idle("t5_rst", 1'b0);
    repeat (2) @(negedge clk2);
    chk("t5_quiet_valid", 32'(s_valid), 32'd0);
    start_frame(1);
    run_frame("t5_new", 1, 1'b0, 0, -1, 0, cycles);
    check_idle("t5_end", 1'b0);
    repeat (2) @(negedge clk2);

    // Index ramp pattern: s_idx and s_data_r must track the emitted bin order
    start_frame(2);
    run_frame("t6", 2, 1'b0, 0, -1, 0, cycles);
    check_idle("t6_end", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
